ping_pong_arbiter: RTL and testbench

Shares one Parameterized_Ping_Pong_Counter between two requesters (A, B). Each requester asks for a session with its own [min, max] range and bounce count. The arbiter grants round-robin, resets and configures the counter, and runs it until the requested number of direction reversals. It then hands a done pulse back to the owner. It sits between the requesters and the counter's clk/rst_n/enable/flip/max/min/direction/out pins.

---
 rtl/ping_pong_arbiter_if.sv | 84 ++++++++
 rtl/ping_pong_arbiter.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_ping_pong_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ping_pong_arbiter_if.sv
// -----------------------------------------------------------------------------
// ping_pong_arbiter_if
//
// Purpose: bundles every non-clock signal between the ping-pong arbiter, its
// two requesters (A and B) and the shared ping-pong counter.
//
// Parameters:
//   WIDTH - counter value width (min/max/out)
//   BW    - bounce-count width
//
// Signal groups:
//   requester A/B -> arbiter : req_x, min_x, max_x, bounce_x, flip_x
//   arbiter -> requester A/B : gnt_x, done_x, err_x
//   arbiter -> counter       : cnt_rst_n, cnt_enable, cnt_flip, cnt_min, cnt_max
//   counter -> arbiter       : cnt_direction, cnt_out
//
// Handshake: a requester raises req_x together with stable min_x/max_x/
// bounce_x and keeps req_x high until it sees a one-cycle done_x (session
// completed) or err_x (session rejected or aborted). gnt_x is high while the
// requester owns the counter. Dropping req_x while granted aborts the session
// and is answered with err_x. Range and bounce inputs are sampled only at the
// arbitration edge; later changes have no effect on the running session.
//
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (requesters plus counter)
// -----------------------------------------------------------------------------
interface ping_pong_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int BW    = 8
);
    // Requester side
    logic             req_a;
    logic             req_b;
    logic [WIDTH-1:0] min_a;
    logic [WIDTH-1:0] max_a;
    logic [WIDTH-1:0] min_b;
    logic [WIDTH-1:0] max_b;
    logic [BW-1:0]    bounce_a;
    logic [BW-1:0]    bounce_b;
    logic             flip_a;
    logic             flip_b;
    logic             gnt_a;
    logic             gnt_b;
    logic             done_a;
    logic             done_b;
    logic             err_a;
    logic             err_b;

    // Counter side
    logic             cnt_rst_n;
    logic             cnt_enable;
    logic             cnt_flip;
    logic [WIDTH-1:0] cnt_min;
    logic [WIDTH-1:0] cnt_max;
    logic             cnt_direction;
    logic [WIDTH-1:0] cnt_out;

    modport slave (
        input  req_a, req_b,
        input  min_a, max_a, min_b, max_b,
        input  bounce_a, bounce_b,
        input  flip_a, flip_b,
        output gnt_a, gnt_b,
        output done_a, done_b,
        output err_a, err_b,
        output cnt_rst_n, cnt_enable, cnt_flip,
        output cnt_min, cnt_max,
        input  cnt_direction, cnt_out
    );

    modport master (
        output req_a, req_b,
        output min_a, max_a, min_b, max_b,
        output bounce_a, bounce_b,
        output flip_a, flip_b,
        input  gnt_a, gnt_b,
        input  done_a, done_b,
        input  err_a, err_b,
        input  cnt_rst_n, cnt_enable, cnt_flip,
        input  cnt_min, cnt_max,
        output cnt_direction, cnt_out
    );
endinterface

// File: rtl/ping_pong_arbiter.sv
// -----------------------------------------------------------------------------
// ping_pong_arbiter
//
// Purpose: shares one ping-pong counter between two requesters (A, B). The
// winner of a round-robin arbitration gets the counter reset and configured
// with its own [min, max] range, the counter is run until the requested
// number of direction reversals has been observed, and a done pulse is
// returned to the owner. Invalid ranges (min >= max) are rejected and a
// dropped request during a session aborts it; both answer with an err pulse.
//
// Parameters:
//   WIDTH - counter value width (min/max/out)
//   BW    - bounce-count width
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous reset, active high
//   bus      if   ping_pong_arbiter_if.slave (requester + counter signals)
//   state_o  out  current FSM state (0 IDLE, 1 LOAD, 2 RUN, 3 DONE)
//
// Optional feature: define PPA_FLIP_EN to forward the owner's flip request to
// the counter (registered, one cycle of latency, only in RUN). Without it
// cnt_flip is constant 0 and flip_a/flip_b are ignored.
//
// Timing note: every output is a register loaded from a decode of the
// current state, so outputs trail the state by one cycle. A request sampled
// in IDLE shows up as gnt/cnt_rst_n=0 one edge later, and the done/err pulse
// appears on the IDLE cycle that follows DONE (with gnt already low).
// -----------------------------------------------------------------------------
module ping_pong_arbiter #(
    parameter int WIDTH = 4,
    parameter int BW    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    ping_pong_arbiter_if.slave   bus,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Requester encoding used by owner/last: 0 = A, 1 = B
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    state_e           state_q,    state_d;
    logic             owner_q,    owner_d;
    logic             last_q,     last_d;
    logic             abort_q,    abort_d;      // DONE reached by reject/abort
    logic [WIDTH-1:0] min_q,      min_d;
    logic [WIDTH-1:0] max_q,      max_d;
    logic [BW-1:0]    bounce_q,   bounce_d;
    logic [BW-1:0]    rev_cnt_q,  rev_cnt_d;
    logic             prev_dir_q, prev_dir_d;

    // -------------------------------------------------------------------------
    // Registered outputs
    // -------------------------------------------------------------------------
    logic             gnt_a_q,      gnt_a_d;
    logic             gnt_b_q,      gnt_b_d;
    logic             done_a_q,     done_a_d;
    logic             done_b_q,     done_b_d;
    logic             err_a_q,      err_a_d;
    logic             err_b_q,      err_b_d;
    logic             cnt_rst_n_q,  cnt_rst_n_d;
    logic             cnt_enable_q, cnt_enable_d;
    logic             cnt_flip_q,   cnt_flip_d;
    logic [WIDTH-1:0] cnt_min_q,    cnt_min_d;
    logic [WIDTH-1:0] cnt_max_q,    cnt_max_d;

    // -------------------------------------------------------------------------
    // Arbitration helpers
    // -------------------------------------------------------------------------
    logic             any_req;
    logic             pick_b;
    logic [WIDTH-1:0] sel_min;
    logic [WIDTH-1:0] sel_max;
    logic [BW-1:0]    sel_bounce;
    logic             req_own;
    logic             reversal;
    logic [BW-1:0]    rev_inc;

    assign any_req = bus.req_a | bus.req_b;

    // B wins when it is the only requester, or on a tie when A was served last.
    assign pick_b     = bus.req_b && (!bus.req_a || (last_q == SEL_A));
    assign sel_min    = pick_b ? bus.min_b    : bus.min_a;
    assign sel_max    = pick_b ? bus.max_b    : bus.max_a;
    assign sel_bounce = pick_b ? bus.bounce_b : bus.bounce_a;

    assign req_own  = (owner_q == SEL_B) ? bus.req_b : bus.req_a;
    assign reversal = (bus.cnt_direction != prev_dir_q);
    assign rev_inc  = rev_cnt_q + BW'(1);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        abort_d    = abort_q;
        min_d      = min_q;
        max_d      = max_q;
        bounce_d   = bounce_q;
        rev_cnt_d  = rev_cnt_q;
        prev_dir_d = prev_dir_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d  = pick_b ? SEL_B : SEL_A;
                    min_d    = sel_min;
                    max_d    = sel_max;
                    bounce_d = sel_bounce;
                    if (sel_min >= sel_max) begin
                        // Empty or inverted range: answer with err, never grant.
                        abort_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        abort_d = 1'b0;
                        state_d = LOAD;
                    end
                end
            end

            LOAD: begin
                rev_cnt_d  = '0;
                prev_dir_d = 1'b1;          // counter leaves reset counting up
                state_d    = (bounce_q == '0) ? DONE : RUN;
            end

            RUN: begin
                if (!req_own) begin
                    abort_d = 1'b1;
                    state_d = DONE;
                end else if (cnt_enable_q) begin
                    // Direction is only trusted once the counter is enabled:
                    // during the first RUN cycle it is still being held in
                    // reset and may show the previous session's direction.
                    prev_dir_d = bus.cnt_direction;
                    if (reversal) begin
                        rev_cnt_d = rev_inc;
                        if (rev_inc == bounce_q) begin
                            state_d = DONE;
                        end
                    end
                end
            end

            DONE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode (loaded into the output registers)
    // -------------------------------------------------------------------------
    logic own_a;
    logic own_b;
    logic granted;

    assign own_a   = (owner_q == SEL_A);
    assign own_b   = (owner_q == SEL_B);
    assign granted = (state_q == LOAD) || (state_q == RUN);

    always_comb begin
        gnt_a_d      = granted && own_a;
        gnt_b_d      = granted && own_b;
        done_a_d     = (state_q == DONE) && !abort_q && own_a;
        done_b_d     = (state_q == DONE) && !abort_q && own_b;
        err_a_d      = (state_q == DONE) &&  abort_q && own_a;
        err_b_d      = (state_q == DONE) &&  abort_q && own_b;
        cnt_rst_n_d  = (state_q != LOAD);
        cnt_enable_d = (state_q == RUN);
        cnt_min_d    = cnt_min_q;
        cnt_max_d    = cnt_max_q;
        // Range is only pushed to the counter during LOAD and is held
        // afterwards, so it survives until the next session starts.
        if (state_q == LOAD) begin
            cnt_min_d = min_q;
            cnt_max_d = max_q;
        end
    end

`ifdef PPA_FLIP_EN
    logic flip_own;
    logic unused_cnt_out;

    // Only the current owner may flip the counter; the other flip is dropped.
    assign flip_own       = own_b ? bus.flip_b : bus.flip_a;
    assign cnt_flip_d     = (state_q == RUN) && flip_own;
    assign unused_cnt_out = ^bus.cnt_out;
`else
    logic unused_inputs;

    assign cnt_flip_d    = 1'b0;
    assign unused_inputs = ^{bus.cnt_out, bus.flip_a, bus.flip_b};
`endif

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= SEL_A;
            last_q       <= SEL_B;      // so A wins the first tie
            abort_q      <= 1'b0;
            min_q        <= '0;
            max_q        <= '0;
            bounce_q     <= '0;
            rev_cnt_q    <= '0;
            prev_dir_q   <= 1'b1;
            gnt_a_q      <= 1'b0;
            gnt_b_q      <= 1'b0;
            done_a_q     <= 1'b0;
            done_b_q     <= 1'b0;
            err_a_q      <= 1'b0;
            err_b_q      <= 1'b0;
            cnt_rst_n_q  <= 1'b1;
            cnt_enable_q <= 1'b0;
            cnt_flip_q   <= 1'b0;
            cnt_min_q    <= '0;
            cnt_max_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            abort_q      <= abort_d;
            min_q        <= min_d;
            max_q        <= max_d;
            bounce_q     <= bounce_d;
            rev_cnt_q    <= rev_cnt_d;
            prev_dir_q   <= prev_dir_d;
            gnt_a_q      <= gnt_a_d;
            gnt_b_q      <= gnt_b_d;
            done_a_q     <= done_a_d;
            done_b_q     <= done_b_d;
            err_a_q      <= err_a_d;
            err_b_q      <= err_b_d;
            cnt_rst_n_q  <= cnt_rst_n_d;
            cnt_enable_q <= cnt_enable_d;
            cnt_flip_q   <= cnt_flip_d;
            cnt_min_q    <= cnt_min_d;
            cnt_max_q    <= cnt_max_d;
        end
    end

    // -------------------------------------------------------------------------
    // Port drive
    // -------------------------------------------------------------------------
    assign bus.gnt_a      = gnt_a_q;
    assign bus.gnt_b      = gnt_b_q;
    assign bus.done_a     = done_a_q;
    assign bus.done_b     = done_b_q;
    assign bus.err_a      = err_a_q;
    assign bus.err_b      = err_b_q;
    assign bus.cnt_rst_n  = cnt_rst_n_q;
    assign bus.cnt_enable = cnt_enable_q;
    assign bus.cnt_flip   = cnt_flip_q;
    assign bus.cnt_min    = cnt_min_q;
    assign bus.cnt_max    = cnt_max_q;

    assign state_o = state_q;

endmodule

// File: tb/tb_ping_pong_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ping_pong_arbiter
//
// Directed bench for ping_pong_arbiter. A behavioural ping-pong counter is
// attached to the counter pins. Stimulus tasks push the hand-computed grants
// and done/err results into queues; a negedge monitor pops and compares them
// whenever the DUT raises a grant or a done/err pulse.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ping_pong_arbiter;
    localparam int WIDTH = 4;
    localparam int BW    = 8;
    localparam int RW    = 4;                   // {done_a, done_b, err_a, err_b}
    localparam int GW    = 1 + 2 * WIDTH + 8;   // {owner, min, max, gnt_len}

    localparam logic [RW-1:0] RES_DONE_A = 4'b1000;
    localparam logic [RW-1:0] RES_DONE_B = 4'b0100;
    localparam logic [RW-1:0] RES_ERR_A  = 4'b0010;
    localparam logic [RW-1:0] RES_ERR_B  = 4'b0001;

    // ---------------------------------------------------------------- clock/reset
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    ping_pong_arbiter_if #(.WIDTH(WIDTH), .BW(BW)) bus ();

    ping_pong_arbiter #(.WIDTH(WIDTH), .BW(BW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_dbg)
    );

    initial begin
        #300000;
        $display("FAIL watchdog time_limit actual=expired required=finished");
        $fatal(1);
    end

    // ---------------------------------------------------------- counter model
    logic             ctr_dir = 1'b1;
    logic [WIDTH-1:0] ctr_out = '0;

    always @(posedge clk) begin
        if (!bus.cnt_rst_n) begin
            ctr_out <= bus.cnt_min;
            ctr_dir <= 1'b1;
        end else if (bus.cnt_enable) begin
            if (bus.cnt_flip) begin
                ctr_dir <= ~ctr_dir;
                ctr_out <= ctr_dir ? ctr_out - 4'd1 : ctr_out + 4'd1;
            end else if (ctr_dir && ctr_out >= bus.cnt_max) begin
                ctr_dir <= 1'b0;
                ctr_out <= ctr_out - 4'd1;
            end else if (!ctr_dir && ctr_out <= bus.cnt_min) begin
                ctr_dir <= 1'b1;
                ctr_out <= ctr_out + 4'd1;
            end else begin
                ctr_out <= ctr_dir ? ctr_out + 4'd1 : ctr_out - 4'd1;
            end
        end
    end

    assign bus.cnt_direction = ctr_dir;
    assign bus.cnt_out       = ctr_out;

    // ---------------------------------------------------------------- scoreboard
    int             checks = 0;
    int             errors = 0;
    logic [RW-1:0]  exp_q[$];
    logic [GW-1:0]  gnt_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [GW-1:0] gitem(input logic owner, input logic [WIDTH-1:0] mn,
                                            input logic [WIDTH-1:0] mx, input logic [7:0] len);
        return {owner, mn, mx, len};
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_gnt"},       {30'd0, bus.gnt_a, bus.gnt_b}, 0);
        check({tag, "_done"},      {30'd0, bus.done_a, bus.done_b}, 0);
        check({tag, "_err"},       {30'd0, bus.err_a, bus.err_b}, 0);
        check({tag, "_cnt_rst_n"}, {31'd0, bus.cnt_rst_n}, 1);
        check({tag, "_cnt_en"},    {31'd0, bus.cnt_enable}, 0);
        check({tag, "_cnt_flip"},  {31'd0, bus.cnt_flip}, 0);
        check({tag, "_cnt_max"},   {28'd0, bus.cnt_max}, 0);
        check({tag, "_state"},     {30'd0, state_dbg}, 0);
    endtask

    // ---------------------------------------------------------------- monitor
    logic           gnt_prev    = 1'b0;
    logic [RW-1:0]  pulse_prev  = '0;
    logic           load_seen   = 1'b0;
    int             gnt_len_cnt = 0;
    logic [7:0]     gnt_len_exp = '0;
    logic [GW-1:0]  g_item;
    logic [RW-1:0]  e_item;
    logic [RW-1:0]  pulse_now;
    logic           gnt_now;

    always @(negedge clk) begin
        if (rst) begin
            gnt_prev    = 1'b0;
            pulse_prev  = '0;
            load_seen   = 1'b0;
            gnt_len_cnt = 0;
        end else begin
            gnt_now   = bus.gnt_a | bus.gnt_b;
            pulse_now = {bus.done_a, bus.done_b, bus.err_a, bus.err_b};

            if (load_seen) begin
                check("run_cnt_rst_n", {31'd0, bus.cnt_rst_n}, 1);
                load_seen = 1'b0;
            end

            if (gnt_now && !gnt_prev) begin
                if (gnt_q.size() == 0) begin
                    check("unexpected_grant", {30'd0, bus.gnt_a, bus.gnt_b}, 0);
                end else begin
                    g_item = gnt_q.pop_front();
                    check("grant_owner", {30'd0, bus.gnt_a, bus.gnt_b}, g_item[16] ? 32'd1 : 32'd2);
                    check("load_cnt_min", {28'd0, bus.cnt_min}, {28'd0, g_item[15:12]});
                    check("load_cnt_max", {28'd0, bus.cnt_max}, {28'd0, g_item[11:8]});
                    check("load_cnt_rst_n", {31'd0, bus.cnt_rst_n}, 0);
                    check("load_cnt_en", {31'd0, bus.cnt_enable}, 0);
                    gnt_len_exp = g_item[7:0];
                    gnt_len_cnt = 0;
                    load_seen   = 1'b1;
                end
            end
            if (gnt_now) gnt_len_cnt++;

            if (pulse_now != '0) begin
                if (pulse_prev != '0) begin
                    check("pulse_width", {28'd0, pulse_now}, 0);
                end else if (exp_q.size() == 0) begin
                    check("unexpected_result", {28'd0, pulse_now}, 0);
                end else begin
                    e_item = exp_q.pop_front();
                    check("result", {28'd0, pulse_now}, {28'd0, e_item});
                    check("gnt_low_at_result", {31'd0, gnt_now}, 0);
                    check("enable_low_at_result", {31'd0, bus.cnt_enable}, 0);
                    if ((e_item[3] | e_item[2]) && gnt_len_exp != 8'd0)
                        check("gnt_length", gnt_len_cnt, {24'd0, gnt_len_exp});
                end
            end

            gnt_prev   = gnt_now;
            pulse_prev = pulse_now;
        end
    end

    // ---------------------------------------------------------------- drivers
    function automatic logic own_gnt(input logic is_b);
        return is_b ? bus.gnt_b : bus.gnt_a;
    endfunction

    function automatic logic own_pulse(input logic is_b);
        return is_b ? (bus.done_b | bus.err_b) : (bus.done_a | bus.err_a);
    endfunction

    task automatic set_req(input logic is_b, input logic val);
        if (is_b) bus.req_b = val;
        else      bus.req_a = val;
    endtask

    // Raises a request and holds it until done/err; drop_after >= 0 drops the
    // request that many cycles after the grant was first seen.
    task automatic session(input logic is_b, input logic [WIDTH-1:0] mn, input logic [WIDTH-1:0] mx,
                           input logic [BW-1:0] bn, input int drop_after, output int lat);
        logic seen_gnt;
        logic got;
        int   gcount;
        seen_gnt = 1'b0;
        got      = 1'b0;
        gcount   = 0;
        lat      = -1;
        if (is_b) begin
            bus.min_b = mn; bus.max_b = mx; bus.bounce_b = bn;
        end else begin
            bus.min_a = mn; bus.max_a = mx; bus.bounce_a = bn;
        end
        set_req(is_b, 1'b1);
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (lat < 0 && (own_gnt(is_b) || own_pulse(is_b))) lat = i;
            if (own_gnt(is_b)) seen_gnt = 1'b1;
            if (seen_gnt && drop_after >= 0) begin
                if (gcount == drop_after) set_req(is_b, 1'b0);
                gcount++;
            end
            if (own_pulse(is_b)) got = 1'b1;
        end
        if (!got) check("session_timeout", 0, 1);
        set_req(is_b, 1'b0);
    endtask

`ifdef PPA_FLIP_EN
    task automatic flip_session();
        int phase;
        phase = 0;
        bus.min_a = 4'd0; bus.max_a = 4'd15; bus.bounce_a = 8'd1;
        bus.req_a = 1'b1;
        for (int i = 0; i < 200 && phase < 5; i++) begin
            @(negedge clk);
            case (phase)
                0: if (bus.cnt_enable && bus.cnt_out == 4'd2) begin bus.flip_b = 1'b1; phase = 1; end
                1: begin check("flip_b_ignored", {31'd0, bus.cnt_flip}, 0); bus.flip_b = 1'b0; phase = 2; end
                2: if (bus.cnt_enable && bus.cnt_out == 4'd5) begin bus.flip_a = 1'b1; phase = 3; end
                3: begin check("flip_a_latency", {31'd0, bus.cnt_flip}, 1); bus.flip_a = 1'b0; phase = 4; end
                default: if (bus.done_a || bus.err_a) phase = 5;
            endcase
        end
        if (phase != 5) check("flip_timeout", phase, 5);
        bus.req_a = 1'b0;
    endtask
`endif

    // ---------------------------------------------------------------- stimulus
    initial begin
        int lat;
        bus.req_a = 1'b0; bus.req_b = 1'b0;
        bus.min_a = '0; bus.max_a = '0; bus.min_b = '0; bus.max_b = '0;
        bus.bounce_a = '0; bus.bounce_b = '0;
        bus.flip_a = 1'b0; bus.flip_b = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("in_reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("after_reset");

        // Tie right after reset: A first (last = B), then B.
        gnt_q.push_back(gitem(1'b0, 4'd0, 4'd3, 8'd7));
        gnt_q.push_back(gitem(1'b1, 4'd0, 4'd3, 8'd7));
        exp_q.push_back(RES_DONE_A);
        exp_q.push_back(RES_DONE_B);
        fork
            begin int l; session(1'b0, 4'd0, 4'd3, 8'd1, -1, l); end
            begin int l; session(1'b1, 4'd0, 4'd3, 8'd1, -1, l); end
        join
        repeat (2) @(negedge clk);

        // A alone, full range, two bounces: 34 granted cycles.
        gnt_q.push_back(gitem(1'b0, 4'd0, 4'd15, 8'd34));
        exp_q.push_back(RES_DONE_A);
        session(1'b0, 4'd0, 4'd15, 8'd2, -1, lat);
        check("grant_latency", lat, 1);
        repeat (2) @(negedge clk);

        // Tie with last = A: B first, then A.
        gnt_q.push_back(gitem(1'b1, 4'd2, 4'd6, 8'd8));
        gnt_q.push_back(gitem(1'b0, 4'd0, 4'd3, 8'd7));
        exp_q.push_back(RES_DONE_B);
        exp_q.push_back(RES_DONE_A);
        fork
            begin int l; session(1'b0, 4'd0, 4'd3, 8'd1, -1, l); end
            begin int l; session(1'b1, 4'd2, 4'd6, 8'd1, -1, l); end
        join
        repeat (2) @(negedge clk);

        // Inverted range from B: err, no grant.
        exp_q.push_back(RES_ERR_B);
        session(1'b1, 4'd15, 4'd0, 8'd3, -1, lat);
        check("reject_latency", lat, 1);
        repeat (2) @(negedge clk);

        // A drops its request six cycles into the session: abort.
        gnt_q.push_back(gitem(1'b0, 4'd8, 4'd11, 8'd0));
        exp_q.push_back(RES_ERR_A);
        session(1'b0, 4'd8, 4'd11, 8'd5, 6, lat);
        repeat (2) @(negedge clk);

        // Zero bounces: grant for LOAD only, then done.
        gnt_q.push_back(gitem(1'b1, 4'd1, 4'd9, 8'd1));
        exp_q.push_back(RES_DONE_B);
        session(1'b1, 4'd1, 4'd9, 8'd0, -1, lat);
        repeat (2) @(negedge clk);

`ifdef PPA_FLIP_EN
        gnt_q.push_back(gitem(1'b0, 4'd0, 4'd15, 8'd0));
        exp_q.push_back(RES_DONE_A);
        flip_session();
        repeat (2) @(negedge clk);
`endif

        // Reset in the middle of a RUN: outputs return at once, no result.
        gnt_q.push_back(gitem(1'b0, 4'd0, 4'd15, 8'd0));
        bus.min_a = 4'd0; bus.max_a = 4'd15; bus.bounce_a = 8'd3;
        bus.req_a = 1'b1;
        repeat (8) @(negedge clk);
        check("mid_run_enable", {31'd0, bus.cnt_enable}, 1);
        rst = 1'b1;
        #1;
        check_reset_values("mid_rst");
        bus.req_a = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        check("exp_q_empty", exp_q.size(), 0);
        check("gnt_q_empty", gnt_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
